// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: state encoding, per-boundary widths, NOP control.
package pipe_pkg;
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_e;

   localparam int IFID_CTRL_W  = 10;
   localparam int IFID_DATA_W  = 136;
   localparam int IDEX_CTRL_W  = 10;
   localparam int IDEX_DATA_W  = 136;
   localparam int EXMEM_CTRL_W = 10;
   localparam int EXMEM_DATA_W = 136;
   localparam int MEMWB_CTRL_W = 10;
   localparam int MEMWB_DATA_W = 136;

   // A NOP bubble is an all-zero control field; replicate this bit to any width.
   localparam logic NOP_CTRL_BIT = 1'b0;
endpackage

// File: rtl/pipe_entry.sv
// One held payload: control + data register with a valid bit, load enable and synchronous clear.
import pipe_pkg::*;

module pipe_entry #(
   parameter int CTRL_W = IDEX_CTRL_W,
   parameter int DATA_W = IDEX_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              ld,
   input  logic [CTRL_W-1:0] ctrl_d,
   input  logic [DATA_W-1:0] data_d,
   output logic              v_q,
   output logic [CTRL_W-1:0] ctrl_q,
   output logic [DATA_W-1:0] data_q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q    <= 1'b0;
         ctrl_q <= {CTRL_W{NOP_CTRL_BIT}};
         data_q <= '0;
      end else if (clr) begin
         v_q    <= 1'b0;
         ctrl_q <= {CTRL_W{NOP_CTRL_BIT}};
         data_q <= '0;
      end else if (ld) begin
         v_q    <= 1'b1;
         ctrl_q <= ctrl_d;
         data_q <= data_d;
      end
   end
endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer; in_ready is registered.
import pipe_pkg::*;

module pipe_stage_skid_reg #(
   parameter int CTRL_W = IDEX_CTRL_W,
   parameter int DATA_W = IDEX_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        count
);
   state_e            st_q, st_d;
   logic              in_ready_q;
   logic              main_ld, main_clr, skid_ld, skid_clr, main_from_skid;
   logic              main_v, skid_v;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic [DATA_W-1:0] main_data, skid_data;
   logic              in_fire, out_fire;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = main_v & out_ready;

   always_comb begin
      st_d           = st_q;
      main_ld        = 1'b0;
      main_clr       = 1'b0;
      skid_ld        = 1'b0;
      skid_clr       = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         main_clr = 1'b1;
         skid_clr = 1'b1;
         st_d     = EMPTY;
      end else begin
         case (st_q)
            EMPTY: if (in_fire) begin
               main_ld = 1'b1;
               st_d    = FULL;
            end
            FULL: begin
               if (in_fire && !out_fire) begin
                  skid_ld = 1'b1;
                  st_d    = SKID;
               end else if (in_fire) begin
                  main_ld = 1'b1;
               end else if (out_fire) begin
                  main_clr = 1'b1;
                  st_d     = EMPTY;
               end
            end
            SKID: if (out_fire) begin
               main_ld        = 1'b1;
               main_from_skid = 1'b1;
               skid_clr       = 1'b1;
               st_d           = FULL;
            end
            default: begin
               main_clr = 1'b1;
               skid_clr = 1'b1;
               st_d     = EMPTY;
            end
         endcase
      end
   end

   // in_ready tracks the next-state skid occupancy so it never sees out_ready/flush combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q       <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         st_q       <= st_d;
         in_ready_q <= (st_d != SKID);
      end
   end

   pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (main_clr),
      .ld     (main_ld),
      .ctrl_d (main_from_skid ? skid_ctrl : in_ctrl),
      .data_d (main_from_skid ? skid_data : in_data),
      .v_q    (main_v),
      .ctrl_q (main_ctrl),
      .data_q (main_data)
   );

   pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (skid_clr),
      .ld     (skid_ld),
      .ctrl_d (in_ctrl),
      .data_d (in_data),
      .v_q    (skid_v),
      .ctrl_q (skid_ctrl),
      .data_q (skid_data)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = main_v;
   assign out_ctrl  = main_ctrl & {CTRL_W{main_v}};
   assign out_data  = main_data & {DATA_W{main_v}};
   assign count     = {1'b0, main_v} + {1'b0, skid_v};
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed + random bench for pipe_stage_skid_reg against a FIFO-of-depth-2 reference model.
module tb_pipe_stage_skid_reg;
   localparam int CW = 10;
   localparam int DW = 136;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } pay_t;

   logic          clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [DW-1:0] in_data, out_data;
   logic [1:0]    count;

   pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pay_t m_q[$];
   bit   m_ready;
   int   n_vec, n_err;

   function automatic logic [DW-1:0] rnd_data();
      logic [159:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return r[DW-1:0];
   endfunction

   task automatic check(input string tag);
      logic          ev;
      logic [CW-1:0] ec;
      logic [DW-1:0] ed;
      logic [1:0]    en;
      ev = (m_q.size() > 0);
      ec = ev ? m_q[0].c : '0;
      ed = ev ? m_q[0].d : '0;
      en = 2'(m_q.size());
      n_vec += 5;
      assert (out_valid === ev) else begin
         n_err++; $error("FAIL %s out_valid got %0b want %0b", tag, out_valid, ev);
      end
      assert (out_ctrl === ec) else begin
         n_err++; $error("FAIL %s out_ctrl got %h want %h", tag, out_ctrl, ec);
      end
      assert (out_data === ed) else begin
         n_err++; $error("FAIL %s out_data got %h want %h", tag, out_data, ed);
      end
      assert (count === en) else begin
         n_err++; $error("FAIL %s count got %0d want %0d", tag, count, en);
      end
      assert (in_ready === m_ready) else begin
         n_err++; $error("FAIL %s in_ready got %0b want %0b", tag, in_ready, m_ready);
      end
   endtask

   // Drive one cycle, advance the model across the edge, check at the following negedge.
   task automatic step(input string tag, input bit iv, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input bit ordy, input bit fl, output bit acc);
      bit deliv;
      in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
      acc   = iv && m_ready;
      deliv = ordy && (m_q.size() > 0);
      @(posedge clk);
      if (deliv) void'(m_q.pop_front());
      if (fl) m_q.delete();
      else if (acc) m_q.push_back('{c: c, d: d});
      m_ready = (m_q.size() < 2);
      @(negedge clk);
      check(tag);
   endtask

   initial begin
      bit acc;
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = '0; in_data = '0;
      m_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset");
      rst_n = 1'b1;
      repeat (3) step("idle", 0, '0, '0, 1, 0, acc);

      for (int i = 1; i <= 8; i++) step("stream", 1, CW'(10'h3C0 + i), rnd_data(), 1, 0, acc);
      step("stream_drain", 0, '0, '0, 1, 0, acc);

      step("bp_A", 1, 10'h011, rnd_data(), 0, 0, acc);
      step("bp_B", 1, 10'h022, rnd_data(), 0, 0, acc);
      begin
         logic [DW-1:0] dc;
         dc = rnd_data();
         repeat (3) step("bp_C_held", 1, 10'h033, dc, 0, 0, acc);
         acc = 1'b0;
         for (int k = 0; k < 5 && !acc; k++) step("bp_release", 1, 10'h033, dc, 1, 0, acc);
         assert (acc) else begin n_err++; $error("FAIL bp_C_accept got 0 want 1"); end
         n_vec++;
      end
      repeat (3) step("bp_drain", 0, '0, '0, 1, 0, acc);

      step("fl_A", 1, 10'h011, rnd_data(), 0, 0, acc);
      step("fl_B", 1, 10'h022, rnd_data(), 0, 0, acc);
      step("flush_skid", 1, 10'h033, rnd_data(), 0, 1, acc);
      step("after_flush", 0, '0, '0, 1, 0, acc);
      step("flush_empty", 0, '0, '0, 0, 1, acc);

      step("flo_A", 1, 10'h011, rnd_data(), 0, 0, acc);
      step("flush_outfire", 0, '0, '0, 1, 1, acc);
      step("flo_after", 0, '0, '0, 1, 0, acc);

      step("ar_A", 1, 10'h011, rnd_data(), 0, 0, acc);
      step("ar_B", 1, 10'h022, rnd_data(), 0, 0, acc);
      in_valid = 1'b0; out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      m_q.delete(); m_ready = 1'b1;
      check("async_reset");
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      step("post_reset", 1, 10'h155, rnd_data(), 1, 0, acc);

      for (int i = 0; i < 400; i++)
         step("random", $urandom_range(0, 3) != 0, CW'($urandom), rnd_data(),
              $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, acc);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end
endmodule
